// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RV32I control path:
// opcodes, datapath mux selects, ALU ops and FSM states.
package riscv_pkg;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RT   = 7'b0110011;
  localparam logic [6:0] OP_BT   = 7'b1100011;
  localparam logic [6:0] OP_IT   = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_PB  = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // aluOp as seen by alu_decoder
  localparam logic [1:0] AOP_ADD  = 2'b00;
  localparam logic [1:0] AOP_SUB  = 2'b01;
  localparam logic [1:0] AOP_FUNC = 2'b10;
  localparam logic [1:0] AOP_PB   = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR1,
    S_JALR2,
    S_LUI,
    S_HALT
  } state_t;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       done;
  } ctrl_t;

  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.src_b      = SRCB_FOUR;
        c.result_src = RES_ALU;
        c.pc_update  = 1'b1;
      end
      S_DECODE: begin
        c.src_a = SRCA_OLDPC;
        c.src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        c.src_a = SRCA_RS1;
        c.src_b = SRCB_IMM;
      end
      S_MEMREAD: c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECR: begin
        c.src_a  = SRCA_RS1;
        c.alu_op = AOP_FUNC;
      end
      S_EXECI: begin
        c.src_a  = SRCA_RS1;
        c.src_b  = SRCB_IMM;
        c.alu_op = AOP_FUNC;
      end
      S_ALUWB: c.reg_write = 1'b1;
      S_BRANCH: begin
        c.src_a  = SRCA_RS1;
        c.alu_op = AOP_SUB;
        c.branch = 1'b1;
      end
      S_JAL, S_JALR2: begin
        c.src_a     = SRCA_OLDPC;
        c.src_b     = SRCB_FOUR;
        c.pc_update = 1'b1;
      end
      S_JALR1: begin
        c.src_a = SRCA_RS1;
        c.src_b = SRCB_IMM;
      end
      S_LUI: begin
        c.src_b  = SRCB_IMM;
        c.alu_op = AOP_PB;
      end
      S_HALT: c.done = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    logic [2:0] r;
    r = IMM_I;
    unique case (1'b1)
      (op == OP_SW):  r = IMM_S;
      (op == OP_BT):  r = IMM_B;
      (op == OP_JAL): r = IMM_J;
      (op == OP_LUI): r = IMM_U;
      default:        r = IMM_I;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the sequencing FSM and the
// multi-cycle datapath.
interface multicycle_controller_if;

  logic [6:0] op;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       zero;
  logic       lt;

  logic       pcWrite;
  logic       adrSrc;
  logic       memWrite;
  logic       irWrite;
  logic [1:0] resultSrc;
  logic [1:0] aluSrcA;
  logic [1:0] aluSrcB;
  logic [2:0] aluControl;
  logic [2:0] immSrc;
  logic       regWrite;
  logic       done;

  modport master (
    input  op, func3, func7, zero, lt,
    output pcWrite, adrSrc, memWrite, irWrite,
    output resultSrc, aluSrcA, aluSrcB,
    output aluControl, immSrc, regWrite, done
  );

  modport slave (
    output op, func3, func7, zero, lt,
    input  pcWrite, adrSrc, memWrite, irWrite,
    input  resultSrc, aluSrcA, aluSrcB,
    input  aluControl, immSrc, regWrite, done
  );

endinterface

// File: rtl/alu_decoder.sv
// ALU control decoder carried over from the single-cycle
// core so the existing ALU encoding stays unchanged.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] aluOp,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output logic [2:0] aluControl
);

  logic rsub;

  // funct7 of an I-type is immediate bits, so only R-type may subtract
  assign rsub = (op == OP_RT) && (func7 == 7'b0100000);

  always_comb begin
    aluControl = ALU_ADD;
    case (aluOp)
      AOP_ADD: aluControl = ALU_ADD;
      AOP_SUB: aluControl = ALU_SUB;
      AOP_PB:  aluControl = ALU_PB;
      AOP_FUNC: begin
        case (func3)
          3'b000:  aluControl = rsub ? ALU_SUB : ALU_ADD;
          3'b111:  aluControl = ALU_AND;
          3'b110:  aluControl = ALU_OR;
          3'b100:  aluControl = ALU_XOR;
          3'b010:  aluControl = ALU_SLT;
          default: aluControl = ALU_ADD;
        endcase
      end
      default: aluControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencing FSM: state and control
// outputs registered together, branch outcome resolved live.
module multicycle_controller
  import riscv_pkg::*;
(
  input logic                    clk,
  input logic                    rst_n,
  multicycle_controller_if.master bus
);

  state_t     state;
  state_t     nxt;
  ctrl_t      ctrl;
  logic       taken;
  logic [2:0] alu_ctl;

  always_comb begin
    nxt = state;
    case (state)
      S_FETCH: nxt = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (bus.op == OP_LW),
          (bus.op == OP_SW):   nxt = S_MEMADR;
          (bus.op == OP_RT):   nxt = S_EXECR;
          (bus.op == OP_IT):   nxt = S_EXECI;
          (bus.op == OP_BT):   nxt = S_BRANCH;
          (bus.op == OP_JAL):  nxt = S_JAL;
          (bus.op == OP_JALR): nxt = S_JALR1;
          (bus.op == OP_LUI):  nxt = S_LUI;
          default:             nxt = S_HALT;
        endcase
      end
      S_MEMADR:
        nxt = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  nxt = S_MEMWB;
      S_MEMWB:    nxt = S_FETCH;
      S_MEMWRITE: nxt = S_FETCH;
      S_EXECR:    nxt = S_ALUWB;
      S_EXECI:    nxt = S_ALUWB;
      S_ALUWB:    nxt = S_FETCH;
      S_BRANCH:   nxt = S_FETCH;
      S_JAL:      nxt = S_ALUWB;
      S_JALR1:    nxt = S_JALR2;
      S_JALR2:    nxt = S_ALUWB;
      S_LUI:      nxt = S_ALUWB;
      S_HALT:     nxt = S_HALT;
      default:    nxt = S_HALT;
    endcase
  end

  // outputs are registered from the next state, so they stay Moore
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      ctrl  <= ctrl_of(S_FETCH);
    end else begin
      state <= nxt;
      ctrl  <= ctrl_of(nxt);
    end
  end

  always_comb begin
    taken = 1'b0;
    case (bus.func3)
      3'b000:  taken = bus.zero;
      3'b001:  taken = ~bus.zero;
      3'b100:  taken = bus.lt;
      3'b101:  taken = ~bus.lt;
      default: taken = 1'b0;
    endcase
  end

  alu_decoder u_alu_dec (
    .aluOp      (ctrl.alu_op),
    .op         (bus.op),
    .func3      (bus.func3),
    .func7      (bus.func7),
    .aluControl (alu_ctl)
  );

  assign bus.pcWrite    = ctrl.pc_update
                        | (ctrl.branch & taken);
  assign bus.adrSrc     = ctrl.adr_src;
  assign bus.memWrite   = ctrl.mem_write;
  assign bus.irWrite    = ctrl.ir_write;
  assign bus.resultSrc  = ctrl.result_src;
  assign bus.aluSrcA    = ctrl.src_a;
  assign bus.aluSrcB    = ctrl.src_b;
  assign bus.aluControl = alu_ctl;
  assign bus.immSrc     = imm_of(bus.op);
  assign bus.regWrite   = ctrl.reg_write;
  assign bus.done       = ctrl.done;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: expected
// per-cycle control vectors are queued, then checked each cycle.
module tb_multicycle_controller;

  logic clk;
  logic rst_n;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef enum {
    P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_EXR, P_EXI,
    P_AWB, P_BR, P_JAL, P_J1, P_J2, P_LUI, P_HALT
  } ph_t;

  typedef struct {
    string       tag;
    logic [17:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag,
                     input logic [17:0] got,
                     input logic [17:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] obs();
    return {bus.pcWrite, bus.adrSrc, bus.memWrite,
            bus.irWrite, bus.resultSrc, bus.aluSrcA,
            bus.aluSrcB, bus.aluControl, bus.immSrc,
            bus.regWrite, bus.done};
  endfunction

  function automatic logic [2:0] m_imm(input logic [6:0] o);
    case (o)
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] m_ac(input logic [6:0] o,
                                      input logic [2:0] f3,
                                      input logic [6:0] f7);
    case (f3)
      3'b000: return (o == 7'b0110011 && f7 == 7'b0100000)
                     ? 3'b001 : 3'b000;
      3'b111: return 3'b010;
      3'b110: return 3'b011;
      3'b100: return 3'b111;
      3'b010: return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic m_tk(input logic [2:0] f3,
                                input logic z, input logic l);
    case (f3)
      3'b000: return z;
      3'b001: return !z;
      3'b100: return l;
      3'b101: return !l;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [17:0] model(input ph_t p,
                                        input logic [2:0] imm,
                                        input logic [2:0] ac,
                                        input logic tk);
    logic pc, adr, mw, ir, rw, dn;
    logic [1:0] rs, sa, sbs;
    logic [2:0] a;
    {pc, adr, mw, ir, rw, dn} = '0;
    rs = 2'b00; sa = 2'b00; sbs = 2'b00; a = 3'b000;
    case (p)
      P_F:   begin ir = 1; pc = 1; rs = 2'b10; sbs = 2'b10; end
      P_D:   begin sa = 2'b01; sbs = 2'b01; end
      P_MA:  begin sa = 2'b10; sbs = 2'b01; end
      P_MR:  adr = 1;
      P_MWB: begin rs = 2'b01; rw = 1; end
      P_MW:  begin adr = 1; mw = 1; end
      P_EXR: begin sa = 2'b10; a = ac; end
      P_EXI: begin sa = 2'b10; sbs = 2'b01; a = ac; end
      P_AWB: rw = 1;
      P_BR:  begin sa = 2'b10; a = 3'b001; pc = tk; end
      P_JAL: begin sa = 2'b01; sbs = 2'b10; pc = 1; end
      P_J1:  begin sa = 2'b10; sbs = 2'b01; end
      P_J2:  begin sa = 2'b01; sbs = 2'b10; pc = 1; end
      P_LUI: begin sbs = 2'b01; a = 3'b100; end
      P_HALT: dn = 1;
      default: ;
    endcase
    return {pc, adr, mw, ir, rs, sa, sbs, a, imm, rw, dn};
  endfunction

  logic [2:0] c_imm, c_ac;
  logic       c_tk;
  string      c_nm;

  task automatic push(input ph_t p);
    exp_t e;
    e.tag = $sformatf("%s.%s", c_nm, p.name());
    e.v   = model(p, c_imm, c_ac, c_tk);
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      chk(e.tag, obs(), e.v);
    end
  endtask

  task automatic check_now(input string tag);
    exp_t e;
    c_nm = tag;
    push(P_F);
    e = sb.pop_front();
    chk(e.tag, obs(), e.v);
  endtask

  task automatic setup(input string nm, input logic [6:0] o,
                       input logic [2:0] f3, input logic [6:0] f7,
                       input logic z, input logic l);
    bus.op = o; bus.func3 = f3; bus.func7 = f7;
    bus.zero = z; bus.lt = l;
    c_nm  = nm;
    c_imm = m_imm(o);
    c_ac  = m_ac(o, f3, f7);
    c_tk  = m_tk(f3, z, l);
  endtask

  task automatic run(input string nm, input logic [6:0] o,
                     input logic [2:0] f3, input logic [6:0] f7,
                     input logic z, input logic l);
    setup(nm, o, f3, f7, z, l);
    push(P_F);
    push(P_D);
    case (o)
      7'b0000011: begin push(P_MA); push(P_MR); push(P_MWB); end
      7'b0100011: begin push(P_MA); push(P_MW); end
      7'b0110011: begin push(P_EXR); push(P_AWB); end
      7'b0010011: begin push(P_EXI); push(P_AWB); end
      7'b1100011: push(P_BR);
      7'b1101111: begin push(P_JAL); push(P_AWB); end
      7'b1100111: begin push(P_J1); push(P_J2); push(P_AWB); end
      7'b0110111: begin push(P_LUI); push(P_AWB); end
      default: for (int i = 0; i < 12; i++) push(P_HALT);
    endcase
    drain();
  endtask

  initial begin
    rst_n = 1'b1;
    setup("rst", 7'b0000000, 3'b000, 7'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #2 check_now("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    run("lw",   7'b0000011, 3'b010, 7'b0000000, 0, 0);
    run("sub",  7'b0110011, 3'b000, 7'b0100000, 0, 0);
    run("add",  7'b0110011, 3'b000, 7'b0000000, 0, 0);
    run("addi", 7'b0010011, 3'b000, 7'b0100000, 0, 0);
    run("xor",  7'b0110011, 3'b100, 7'b0000000, 0, 0);
    run("ori",  7'b0010011, 3'b110, 7'b0000000, 0, 0);
    run("and",  7'b0110011, 3'b111, 7'b0000000, 0, 0);
    run("slti", 7'b0010011, 3'b010, 7'b0000000, 0, 0);
    run("sll",  7'b0110011, 3'b001, 7'b0000000, 0, 0);
    run("sw",   7'b0100011, 3'b010, 7'b0000000, 0, 0);
    run("bne",  7'b1100011, 3'b001, 7'b0000000, 0, 0);
    run("beq0", 7'b1100011, 3'b000, 7'b0000000, 0, 0);
    run("beq1", 7'b1100011, 3'b000, 7'b0000000, 1, 0);
    run("blt",  7'b1100011, 3'b100, 7'b0000000, 0, 1);
    run("bge",  7'b1100011, 3'b101, 7'b0000000, 0, 1);
    run("bf2",  7'b1100011, 3'b010, 7'b0000000, 1, 1);
    run("jal",  7'b1101111, 3'b000, 7'b0000000, 0, 0);
    run("jalr", 7'b1100111, 3'b000, 7'b0000000, 0, 0);
    run("lui",  7'b0110111, 3'b101, 7'b0000000, 0, 0);

    setup("swrst", 7'b0100011, 3'b010, 7'b0000000, 0, 0);
    push(P_F); push(P_D); push(P_MA); push(P_MW);
    drain();
    #2 rst_n = 1'b0;
    #1 check_now("swrst.async");
    @(posedge clk);
    #1 check_now("swrst.held");
    rst_n = 1'b1;
    run("post", 7'b0110011, 3'b000, 7'b0100000, 0, 0);

    run("ill", 7'b0000000, 3'b000, 7'b0000000, 0, 0);
    #2 rst_n = 1'b0;
    #1 check_now("ill.rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    run("lui2", 7'b0110111, 3'b000, 7'b0000000, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
